// File: rtl/csa_arb_pkg.sv
// rtl/csa_arb_pkg.sv - shared constants and operand/response records for csa_add_arbiter
// Contents:
//    W         operand width of the shared adder slice
//    NREQ_DEF  default number of requesters
//    IDW_MAX   id field width wide enough for the largest supported NREQ (8)
//    op_t      stage-1 operand record {a, b, id}
//    rsp_t     stage-2 response record {sum, cout, id}
package csa_arb_pkg;

   localparam int W        = 9;
   localparam int NREQ_DEF = 4;
   localparam int NREQ_MAX = 8;
   localparam int IDW_MAX  = $clog2(NREQ_MAX);

   typedef struct packed {
      logic [W-1:0]       a;
      logic [W-1:0]       b;
      logic [IDW_MAX-1:0] id;
   } op_t;

   typedef struct packed {
      logic [W-1:0]       sum;
      logic               cout;
      logic [IDW_MAX-1:0] id;
   } rsp_t;

endpackage

// File: rtl/csa_adder9.sv
// rtl/csa_adder9.sv - 9-bit carry-select adder leaf slice
// Ports:
//    i_a, i_b   W-bit operands
//    i_cin      carry in
//    o_sum      (a+b+cin) mod 2^W
//    o_cout     carry out of bit W-1
module csa_adder9
   import csa_arb_pkg::*;
(
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   localparam int LO = 4;
   localparam int HI = W - LO;

   logic [LO:0] w_lo;
   logic [HI:0] w_hi0;
   logic [HI:0] w_hi1;

   // Low block ripples; the high block is computed for both possible carries
   // and the low block's carry picks one.
   assign w_lo  = {1'b0, i_a[LO-1:0]} + {1'b0, i_b[LO-1:0]} + {{LO{1'b0}}, i_cin};
   assign w_hi0 = {1'b0, i_a[W-1:LO]} + {1'b0, i_b[W-1:LO]};
   assign w_hi1 = {1'b0, i_a[W-1:LO]} + {1'b0, i_b[W-1:LO]} + {{HI{1'b0}}, 1'b1};

   assign o_sum[LO-1:0]         = w_lo[LO-1:0];
   assign {o_cout, o_sum[W-1:LO]} = w_lo[LO] ? w_hi1 : w_hi0;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Ports:
//    i_req      request bits, one per requester
//    i_en       grant enable; no grant when low
//    i_ptr      highest-priority requester index for this cycle
//    o_gnt      one-hot grant
//    o_gnt_idx  index of the granted requester
//    o_any      a grant was issued
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic            i_en,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_gnt_idx,
   output logic            o_any
);

   logic [IDW-1:0] w_idx;

   // Scan ptr, ptr+1, ... with wrap; the first active request wins.
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      w_idx     = '0;
      if (i_en) begin
         for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_idx]) begin
               o_gnt[w_idx] = 1'b1;
               o_gnt_idx    = w_idx;
               o_any        = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/csa_add_arbiter.sv
// rtl/csa_add_arbiter.sv - round-robin shared 9-bit adder with two-stage pipeline
// Ports:
//    i_clk, i_rst             clock, synchronous active-high reset
//    i_req_valid/o_req_ready  per-requester handshake
//    i_req_a, i_req_b         packed operands, requester i at [i*W +: W]
//    o_rsp_valid/i_rsp_ready  response handshake
//    o_rsp_id                 requester that issued the response
//    o_rsp_sum, o_rsp_cout    (a+b) mod 2^W and its carry out
//    o_ops_done               saturating count of accepted responses
module csa_add_arbiter
   import csa_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req_valid,
   input  logic [NREQ*W-1:0] i_req_a,
   input  logic [NREQ*W-1:0] i_req_b,
   output logic [NREQ-1:0]   o_req_ready,
   output logic              o_rsp_valid,
   output logic [IDW-1:0]    o_rsp_id,
   output logic [W-1:0]      o_rsp_sum,
   output logic              o_rsp_cout,
   input  logic              i_rsp_ready,
   output logic [CNTW-1:0]   o_ops_done
);

   logic            r_s1_valid;
   op_t             r_s1_op;
   logic            r_rsp_valid;
   rsp_t            r_rsp;
   logic [IDW-1:0]  r_ptr;
   logic [CNTW-1:0] r_ops_done;

   logic            w_s2_adv;
   logic            w_s1_adv;
   logic            w_arb_en;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_gnt_idx;
   logic            w_accept;
   op_t             w_op;
   logic [W-1:0]    w_sum;
   logic            w_cout;
   logic            w_unused_id;

   assign w_s2_adv = !r_rsp_valid || i_rsp_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   // Holding the grant off during reset keeps req_ready low in the reset cycle.
   assign w_arb_en = w_s1_adv && !i_rst;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req     (i_req_valid),
      .i_en      (w_arb_en),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_accept)
   );

   assign o_req_ready = w_gnt;

   always_comb begin
      w_op    = '0;
      w_op.a  = i_req_a[int'(w_gnt_idx)*W +: W];
      w_op.b  = i_req_b[int'(w_gnt_idx)*W +: W];
      w_op.id = IDW_MAX'(w_gnt_idx);
   end

   csa_adder9 u_add (
      .i_a    (r_s1_op.a),
      .i_b    (r_s1_op.b),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_op     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
         r_ptr       <= '0;
         r_ops_done  <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
               r_s1_op <= w_op;
            end
         end
         if (w_s2_adv) begin
            r_rsp_valid <= r_s1_valid;
            r_rsp.sum   <= w_sum;
            r_rsp.cout  <= w_cout;
            r_rsp.id    <= r_s1_op.id;
         end
         if (w_accept) begin
            r_ptr <= (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
         end
         if (r_rsp_valid && i_rsp_ready && (r_ops_done != {CNTW{1'b1}})) begin
            r_ops_done <= r_ops_done + 1'b1;
         end
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp.id[IDW-1:0];
   assign o_rsp_sum   = r_rsp.sum;
   assign o_rsp_cout  = r_rsp.cout;
   assign o_ops_done  = r_ops_done;

   // Id field is sized for the largest requester count; upper bits idle here.
   assign w_unused_id = ^r_rsp.id;

endmodule
